// File: rtl/encode_out_arb.sv
// encode_out_arb: round-robin merge of NCH putn-strobed 64-bit word streams onto one channel-tagged write port.
// Latency: ch_putn low at cycle t -> m_dst_putn low at t+2 at the earliest; m_endn after every channel ended and drained.
// Backpressure: m_full stalls arbitration; words to a full or ended channel are dropped and flag sticky ch_ovf.
// Option: ENCODE_OUT_ARB_WCNT_EN adds per-channel forwarded-word counters on arb_wcnt.

// encode_out_arb_fifo: per-channel word buffer, first-word-fall-through read.
// Latency: written word readable on dout the cycle after push.
// Backpressure: push is refused when full unless the same cycle pops; push_ok reports acceptance.
module encode_out_arb_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         empty,
    output logic         push_ok
);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic [AW:0]   cnt;
    logic          full;

    assign full    = (cnt == (AW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign push_ok = push && (!full || pop);
    assign dout    = mem[rp];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (push_ok) wp <= wp + AW'(1);
            if (pop)     rp <= rp + AW'(1);
            case ({push_ok, pop})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wp] <= din;
    end
endmodule

module encode_out_arb #(
    parameter int NCH   = 4,
    parameter int CW    = 2,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce,
    input  logic [NCH-1:0]    ch_putn,
    input  logic [64*NCH-1:0] ch_dst,
    input  logic [NCH-1:0]    ch_endn,
    output logic [NCH-1:0]    ch_ovf,
    input  logic              m_full,
    output logic              m_dst_putn,
    output logic [63:0]       m_dst,
    output logic [CW-1:0]     m_ch,
    output logic              m_endn
`ifdef ENCODE_OUT_ARB_WCNT_EN
    ,
    output logic [16*NCH-1:0] arb_wcnt
`endif
);
    typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

    state_t         state;
    logic [NCH-1:0] end_l;
    logic [NCH-1:0] f_empty;
    logic [NCH-1:0] push_ok;
    logic [NCH-1:0] pop;
    logic [63:0]    f_dout [NCH];
    logic [CW-1:0]  rr;
    logic [CW-1:0]  gnt;
    logic [CW-1:0]  gidx;
    logic           gnt_vld;
    logic           pop_en;
    int             sidx;
    logic           putn_r;
    logic           endn_r;
    logic [63:0]    dst_r;
    logic [CW-1:0]  ch_r;

    // Ended channels never push, so a late word shows up as a refused push.
    for (genvar i = 0; i < NCH; i++) begin : g_ch
        encode_out_arb_fifo #(.W(64), .DEPTH(DEPTH), .AW(AW)) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .push    (!ch_putn[i] && !end_l[i]),
            .pop     (pop[i]),
            .din     (ch_dst[64*i +: 64]),
            .dout    (f_dout[i]),
            .empty   (f_empty[i]),
            .push_ok (push_ok[i])
        );
    end

    always_comb begin
        gnt     = rr;
        gnt_vld = 1'b0;
        sidx    = 0;
        gidx    = '0;
        for (int k = 0; k < NCH; k++) begin
            sidx = int'(rr) + k;
            if (sidx >= NCH) sidx = sidx - NCH;
            gidx = CW'(sidx);
            if (!gnt_vld && !f_empty[gidx]) begin
                gnt     = gidx;
                gnt_vld = 1'b1;
            end
        end
    end

    assign pop_en = gnt_vld && !m_full && (state != DONE);
    assign pop    = pop_en ? (NCH'(1) << gnt) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= RUN;
            rr     <= '0;
            end_l  <= '0;
            ch_ovf <= '0;
            putn_r <= 1'b1;
            dst_r  <= '0;
            ch_r   <= '0;
            endn_r <= 1'b1;
        end else begin
            end_l  <= end_l | ~ch_endn;
            ch_ovf <= ch_ovf | (~ch_putn & ~push_ok);
            putn_r <= !pop_en;
            if (pop_en) begin
                dst_r <= f_dout[gnt];
                ch_r  <= gnt;
                rr    <= (int'(gnt) == NCH-1) ? '0 : gnt + CW'(1);
            end
            case (state)
                RUN:   if (&end_l) state <= DRAIN;
                // No pop this cycle, so m_endn never falls alongside a word strobe.
                DRAIN: if (&f_empty && !pop_en) begin
                    state  <= DONE;
                    endn_r <= 1'b0;
                end
                default: endn_r <= 1'b0;
            endcase
        end
    end

    assign m_dst_putn = ce ? putn_r : 1'bz;
    assign m_dst      = ce ? dst_r  : {64{1'bz}};
    assign m_ch       = ce ? ch_r   : {CW{1'bz}};
    assign m_endn     = ce ? endn_r : 1'bz;

`ifdef ENCODE_OUT_ARB_WCNT_EN
    logic [15:0] wcnt [NCH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) wcnt[i] <= '0;
        end else if (pop_en) begin
            wcnt[gnt] <= wcnt[gnt] + 16'd1;
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_wcnt
        assign arb_wcnt[16*i +: 16] = wcnt[i];
    end
`endif
endmodule

// File: tb/tb_encode_out_arb.sv
// Bench for encode_out_arb: queue-based reference model feeds a scoreboard, negedge monitor compares.
`timescale 1ns/1ps
module tb_encode_out_arb;
    localparam int NCH   = 4;
    localparam int CW    = 2;
    localparam int DEPTH = 4;
    localparam int AW    = 2;
    localparam logic [63:0] ZPAT = 64'hA5A5_5A5A_0F0F_F0F0;

    logic              clk     = 1'b0;
    logic              rst     = 1'b1;
    logic              ce      = 1'b1;
    logic [NCH-1:0]    ch_putn = '1;
    logic [NCH-1:0]    ch_endn = '1;
    logic [64*NCH-1:0] ch_dst  = '0;
    logic              m_full  = 1'b0;
    wire  [NCH-1:0]    ch_ovf;
    wire               m_dst_putn;
    wire  [63:0]       m_dst;
    wire  [CW-1:0]     m_ch;
    wire               m_endn;
`ifdef ENCODE_OUT_ARB_WCNT_EN
    wire  [16*NCH-1:0] arb_wcnt;
`endif

    // Bench drives a known pattern only while the DUT is meant to float.
    assign m_dst_putn = ce ? 1'bz : 1'b0;
    assign m_endn     = ce ? 1'bz : 1'b0;
    assign m_dst      = ce ? {64{1'bz}} : ZPAT;
    assign m_ch       = ce ? {CW{1'bz}} : CW'(2);

    encode_out_arb #(.NCH(NCH), .CW(CW), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .ce         (ce),
        .ch_putn    (ch_putn),
        .ch_dst     (ch_dst),
        .ch_endn    (ch_endn),
        .ch_ovf     (ch_ovf),
        .m_full     (m_full),
        .m_dst_putn (m_dst_putn),
        .m_dst      (m_dst),
        .m_ch       (m_ch),
        .m_endn     (m_endn)
`ifdef ENCODE_OUT_ARB_WCNT_EN
        ,
        .arb_wcnt   (arb_wcnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [63:0] d;
        int          ch;
        int          cyc;
    } exp_t;

    // Reference model: plain per-channel queues, rr index and end/done flags.
    exp_t           sb[$];
    int             flush_to = 0;
    logic [63:0]    mq [NCH][$];
    logic [NCH-1:0] m_endl = '0;
    logic [NCH-1:0] m_ovf  = '0;
    int             m_rr = 0;
    bit             m_draining = 0;
    bit             m_done = 0;
    int             endn_from = -1;
    int             cyc = 0;
    int             wcnt_m [NCH];
    exp_t           e_new;
    bit             popped;
    bit             all_empty;
    int             g;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                mq[i].delete();
                wcnt_m[i] = 0;
            end
            m_endl = '0;
            m_ovf = '0;
            m_rr = 0;
            m_draining = 0;
            m_done = 0;
            endn_from = -1;
            flush_to = sb.size();
        end else begin
            all_empty = 1;
            for (int i = 0; i < NCH; i++) if (mq[i].size() != 0) all_empty = 0;
            popped = 0;
            if (!m_done && !m_full) begin
                for (int k = 0; k < NCH; k++) begin
                    g = (m_rr + k) % NCH;
                    if (!popped && mq[g].size() != 0) begin
                        e_new.d = mq[g].pop_front();
                        e_new.ch = g;
                        e_new.cyc = cyc + 1;
                        sb.push_back(e_new);
                        wcnt_m[g]++;
                        m_rr = (g + 1) % NCH;
                        popped = 1;
                    end
                end
            end
            for (int i = 0; i < NCH; i++) begin
                if (!ch_putn[i]) begin
                    if (m_endl[i] || mq[i].size() >= DEPTH) m_ovf[i] = 1'b1;
                    else mq[i].push_back(ch_dst[64*i +: 64]);
                end
            end
            if (m_draining && !m_done && all_empty && !popped) begin
                m_done = 1;
                endn_from = cyc + 1;
            end
            if (&m_endl) m_draining = 1;
            m_endl = m_endl | ~ch_endn;
            cyc++;
        end
    end

    int   rd_idx = 0;
    int   last_out = -1;
    int   endn_seen = -1;
    exp_t e_cur;

    always @(negedge clk) begin
        if (rst) begin
            endn_seen = -1;
            last_out = -1;
        end else begin
            if (rd_idx < flush_to) rd_idx = flush_to;
            while (rd_idx < sb.size() && sb[rd_idx].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL missing_word actual=none required=ch%0d:%h", sb[rd_idx].ch, sb[rd_idx].d);
                rd_idx++;
            end
            chk("ch_ovf", 64'(ch_ovf), 64'(m_ovf));
            if (ce) begin
                chk("m_endn", 64'(m_endn), (endn_from >= 0 && cyc >= endn_from) ? 64'd0 : 64'd1);
                if (m_endn === 1'b0 && endn_seen < 0) endn_seen = cyc;
                if (m_dst_putn === 1'b0) begin
                    last_out = cyc;
                    if (rd_idx >= sb.size()) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_word actual=ch%0d:%h required=none", m_ch, m_dst);
                    end else begin
                        e_cur = sb[rd_idx];
                        rd_idx++;
                        chk("m_dst", m_dst, e_cur.d);
                        chk("m_ch", 64'(m_ch), 64'(e_cur.ch));
                        chk("out_cycle", 64'(cyc), 64'(e_cur.cyc));
                    end
                end
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rand_data();
        for (int w = 0; w < 2*NCH; w++) ch_dst[32*w +: 32] = $urandom;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_putn"}, 64'(m_dst_putn), 64'd1);
        chk({tag, "_dst"},  m_dst, 64'd0);
        chk({tag, "_ch"},   64'(m_ch), 64'd0);
        chk({tag, "_endn"}, 64'(m_endn), 64'd1);
        chk({tag, "_ovf"},  64'(ch_ovf), 64'd0);
    endtask

    bit seen;

    initial begin
        tick(3);
        chk_reset_vals("reset");
        rst = 1'b0;
        tick(2);

        // Single channel back-to-back
        ch_putn = 4'b1110; ch_dst[63:0] = 64'hA0A0_0000_0000_00A0; tick();
        ch_dst[63:0] = 64'hA1A1_0000_0000_00A1; tick();
        ch_putn = '1; tick(5);

        // All four channels in one cycle, then ch0+ch3 to see rr back at 0
        rand_data(); ch_putn = '0; tick();
        ch_putn = '1; tick(6);
        rand_data(); ch_putn = 4'b0110; tick();
        ch_putn = '1; tick(4);

        // Backpressure and overflow on ch2
        m_full = 1'b1;
        for (int n = 0; n < 5; n++) begin
            ch_putn = 4'b1011; ch_dst[191:128] = 64'hC000_0000_0000_0000 | 64'(n); tick();
        end
        ch_putn = '1; tick(2);
        chk("ovf_ch2", 64'(ch_ovf), 64'(4'b0100));
        m_full = 1'b0; tick(8);

        // Full FIFO1 accepts a word in the cycle it is popped
        m_full = 1'b1;
        for (int n = 0; n < 4; n++) begin
            ch_putn = 4'b1101; ch_dst[127:64] = 64'hD000_0000_0000_0000 | 64'(n); tick();
        end
        ch_putn = '1; tick();
        m_full = 1'b0; ch_putn = 4'b1101; ch_dst[127:64] = 64'hD000_0000_0000_0004; tick();
        ch_putn = '1; tick(8);
        chk("ovf_ch1_full_pop", 64'(ch_ovf[1]), 64'd0);

        // Random traffic with random backpressure
        for (int n = 0; n < 400; n++) begin
            m_full = ($urandom_range(0, 3) == 0);
            ch_putn = ~(NCH'($urandom) & NCH'($urandom));
            rand_data();
            tick();
        end
        ch_putn = '1; m_full = 1'b0; tick(20);

        // Async reset pulse mid-stream
        for (int n = 0; n < 3; n++) begin
            rand_data(); ch_putn = '0; tick();
        end
        ch_putn = '1;
        #1 rst = 1'b1;
        #1 chk_reset_vals("arst");
        #1 rst = 1'b0;
        tick(6);

        // ce=0 window: outputs float, internal buffering continues
        m_full = 1'b1; tick(2);
        ce = 1'b0;
        for (int n = 0; n < 2; n++) begin
            rand_data(); ch_putn = 4'b1001; tick();
        end
        ch_putn = '1; tick();
        chk("z_putn", 64'(m_dst_putn), 64'd0);
        chk("z_endn", 64'(m_endn), 64'd0);
        chk("z_dst",  m_dst, ZPAT);
        chk("z_ch",   64'(m_ch), 64'd2);
        ce = 1'b1; m_full = 1'b0; tick(8);

        rst = 1'b1; tick(2);
        rst = 1'b0; tick(2);

        // Drain and end with toggling backpressure, plus a late ch3 word
        m_full = 1'b1;
        rand_data(); ch_putn = '0; tick();
        rand_data(); ch_putn = '0; ch_endn = 4'b1110; tick();
        ch_putn = '1; ch_endn = '0; tick();
        rand_data(); ch_putn = 4'b0111; tick();
        ch_putn = '1; tick();
        chk("ovf_late_ch3", 64'(ch_ovf), 64'(4'b1000));
        seen = 0;
        for (int n = 0; n < 100 && !seen; n++) begin
            m_full = ~m_full;
            tick();
            if (m_endn === 1'b0) seen = 1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL endn_timeout actual=%b required=0", m_endn);
        end
        tick(4);
        chk("endn_after_last_word", 64'(endn_seen), 64'(last_out + 1));
        chk("endn_sticky", 64'(m_endn), 64'd0);
        chk("all_words_out", 64'(rd_idx), 64'(sb.size()));
`ifdef ENCODE_OUT_ARB_WCNT_EN
        for (int i = 0; i < NCH; i++) chk("arb_wcnt", 64'(arb_wcnt[16*i +: 16]), 64'(wcnt_m[i]));
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end
endmodule
